// File: rtl/tt_um_priority_irq_ctrl_if.sv
// Pin bundle of the priority IRQ front end: request/control pins in, code and status pins out.
interface tt_um_priority_irq_ctrl_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  modport master (output ena, ui_in, uio_in, input uio_out, uio_oe, uo_out);
  modport slave  (input ena, ui_in, uio_in, output uio_out, uio_oe, uo_out);
endinterface

// File: rtl/tt_um_priority_irq_ctrl.sv
// Registered IRQ front end: sticky per-channel pending capture, masking, fixed-priority
// grant with ack handshake and a post-ack holdoff window.
module tt_um_priority_irq_chan (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic cap,
  input  logic prev_en,
  input  logic edge_mode,
  input  logic clr,
  input  logic clear_all,
  output logic pending,
  output logic ovf_hit
);
  logic req_prev, rise, set;

  assign rise    = req & ~req_prev;
  assign set     = cap & (edge_mode ? rise : req);
  // A repeat edge on a still-pending channel is lost unless the ack retires it this cycle.
  assign ovf_hit = cap & edge_mode & rise & pending & ~clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      req_prev <= 1'b0;
    end else begin
      if (prev_en) req_prev <= req;
      if (clear_all) pending <= 1'b0;
      else           pending <= (pending & ~clr) | set;
    end
  end
endmodule

module tt_um_priority_irq_ctrl #(
  parameter int HOLDOFF = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tt_um_priority_irq_ctrl_if.slave  bus
);
  localparam int NUM_CH = 8;

  typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

  state_t              state, state_nxt;
  logic [2:0]          sel, hi;
  logic [3:0]          cnt;
  logic [NUM_CH-1:0]   mask, pending, clr, ovf_hit, elig;
  logic                ovf, any_pend;
  logic                ack, mask_wr, clear_all, edge_mode;
  logic                unused_pins;

  assign ack         = bus.uio_in[4];
  assign mask_wr     = bus.uio_in[5];
  assign clear_all   = bus.uio_in[6];
  assign edge_mode   = bus.uio_in[7];
  assign unused_pins = ^{bus.ena, bus.uio_in[3:0]};

  assign elig = pending & ~mask;
  assign clr  = (state == PRESENT && ack) ? (NUM_CH'(1) << sel) : '0;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      tt_um_priority_irq_chan u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.ui_in[g]),
        .cap       (~mask_wr),
        .prev_en   (~mask_wr | clear_all),
        .edge_mode (edge_mode),
        .clr       (clr[g]),
        .clear_all (clear_all),
        .pending   (pending[g]),
        .ovf_hit   (ovf_hit[g])
      );
    end
  endgenerate

  always_comb begin
    hi = 3'd0;
    for (int i = 0; i < NUM_CH; i++)
      if (elig[i]) hi = 3'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 3'd0;
      cnt      <= 4'd0;
      mask     <= '0;
      ovf      <= 1'b0;
      any_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      any_pend <= |pending;
      if (clear_all) begin
        ovf <= 1'b0;
        cnt <= 4'd0;
      end else begin
        if (|ovf_hit) ovf <= 1'b1;
        if (mask_wr) mask <= bus.ui_in;
        if (state == IDLE && |elig) sel <= hi;
        if (state == PRESENT && ack) cnt <= 4'(HOLDOFF);
        else if (state == HOLD)      cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|elig) state_nxt = PRESENT;
      PRESENT: if (ack)   state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
      HOLD:    if (cnt <= 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear_all) state_nxt = IDLE;
  end

  // Outputs decode registered state only; no input reaches a pin combinationally.
  always_comb begin
    bus.uo_out  = (state == PRESENT) ? {5'b0, sel} : 8'hF0;
    bus.uio_out = {4'h0, any_pend, state == HOLD, ovf, state == PRESENT};
    bus.uio_oe  = 8'h0F;
  end
endmodule

// File: tb/tb_tt_um_priority_irq_ctrl.sv
// Directed test-plan walk followed by random traffic, all checked against a behavioural model.
module tb_tt_um_priority_irq_ctrl;
  localparam int HO = 2;

  logic clk = 1'b0;
  logic rst_n;
  tt_um_priority_irq_ctrl_if bus ();

  tt_um_priority_irq_ctrl #(.HOLDOFF(HO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] ui;
  logic       ack, mw, ca, em;
  int vecs = 0, errs = 0;

  // Model: what is pending, what is masked, whether a code is on the pins, how many holdoff cycles remain.
  bit [7:0] m_pend, m_mask, m_prev;
  bit       m_ovf, m_pres, m_any;
  int       m_code, m_hold;

  function automatic int top_bit(input bit [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    bit [7:0] pend0, elig, clr, rise, setv;
    pend0 = m_pend;
    elig  = m_pend & ~m_mask;
    if (!rst_n) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_ovf = 0; m_pres = 0; m_hold = 0; m_any = 0;
      return;
    end
    m_any = (pend0 != 0);
    if (ca) begin
      m_pend = 0; m_ovf = 0; m_pres = 0; m_hold = 0; m_prev = ui;
      return;
    end
    clr  = (m_pres && ack) ? 8'(1 << m_code) : 8'h00;
    rise = ui & ~m_prev;
    setv = 0;
    if (!mw) begin
      setv = em ? rise : ui;
      if (em && ((rise & m_pend & ~clr) != 0)) m_ovf = 1;
    end
    m_pend = (m_pend & ~clr) | setv;
    if (mw) m_mask = ui; else m_prev = ui;
    if (m_pres) begin
      if (ack) begin m_pres = 0; m_hold = HO; end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (elig != 0) begin
      m_pres = 1; m_code = top_bit(elig);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bus.ui_in  = ui;
    bus.uio_in = {em, ca, mw, ack, 4'b0};
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("uo_out",  bus.uo_out,  m_pres ? 8'(m_code) : 8'hF0);
    chk("uio_out", bus.uio_out, {4'h0, m_any, m_hold > 0, m_ovf, m_pres});
    chk("uio_oe",  bus.uio_oe,  8'h0F);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_ack();
    ack = 1; tick(); ack = 0;
  endtask

  initial begin
    bus.ena = 1'b1;
    rst_n = 0; ui = 0; ack = 0; mw = 0; ca = 0; em = 1;
    @(negedge clk);
    ticks(2);
    chk("reset_uo", bus.uo_out, 8'hF0);
    chk("reset_uio", bus.uio_out, 8'h00);
    rst_n = 1; tick();

    // Two channels at once, then ack, holdoff, second grant.
    ui = 8'h24; tick(); ui = 0; tick();
    chk("first_grant", bus.uo_out, 8'h05);
    chk("first_irq", bus.uio_out & 8'h01, 8'h01);
    do_ack();
    chk("ack_f0", bus.uo_out, 8'hF0);
    chk("holdoff_on", bus.uio_out & 8'h04, 8'h04);
    ticks(3);
    chk("second_grant", bus.uo_out, 8'h02);
    do_ack(); ticks(3);

    // No preemption by a higher-priority arrival.
    ui = 8'h08; tick(); ui = 0; tick();
    ui = 8'h80; tick(); ui = 0; ticks(2);
    chk("no_preempt", bus.uo_out, 8'h03);
    do_ack(); ticks(3);
    chk("after_preempt", bus.uo_out, 8'h07);
    do_ack(); ticks(3);

    // Masked channel stays pending; unmasking makes it eligible.
    mw = 1; ui = 8'h80; tick(); mw = 0;
    ui = 8'h82; tick(); ui = 0; tick();
    chk("masked_grant", bus.uo_out, 8'h01);
    do_ack(); ticks(3);
    chk("masked_pending", bus.uio_out & 8'h08, 8'h08);
    chk("masked_idle", bus.uo_out, 8'hF0);
    mw = 1; ui = 8'h00; tick(); mw = 0; tick();
    chk("unmask_grant", bus.uo_out, 8'h07);
    do_ack(); ticks(3);

    // Overflow and clear_all.
    ui = 8'h10; tick(); ui = 0; tick(); ui = 8'h10; tick(); ui = 0; tick();
    chk("overflow", bus.uio_out & 8'h02, 8'h02);
    ca = 1; tick(); ca = 0;
    chk("clr_ovf", bus.uio_out & 8'h02, 8'h00);
    chk("clr_uo", bus.uo_out, 8'hF0);
    tick();
    chk("clr_any", bus.uio_out & 8'h08, 8'h00);

    // Level mode: a held request re-presents after holdoff; ack outside PRESENT is ignored.
    em = 0; ui = 8'h04; ticks(2);
    do_ack(); ticks(3);
    chk("level_repeat", bus.uo_out, 8'h02);
    ui = 0; do_ack();
    ack = 1; ticks(4); ack = 0;
    chk("idle_ack", bus.uo_out, 8'hF0);

    // Reset mid-PRESENT clears everything including the mask.
    em = 1; ui = 8'h08; tick(); ui = 0; tick();
    mw = 1; ui = 8'hFF; tick(); mw = 0; ui = 0; tick();
    rst_n = 0; tick();
    chk("rst_uo", bus.uo_out, 8'hF0);
    chk("rst_uio", bus.uio_out, 8'h00);
    rst_n = 1; ui = 8'h40; tick(); ui = 0; tick();
    chk("rst_unmasked", bus.uo_out, 8'h06);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      ui    = 8'($urandom) & 8'($urandom);
      ack   = ($urandom_range(0, 2) == 0);
      mw    = ($urandom_range(0, 11) == 0);
      ca    = ($urandom_range(0, 59) == 0);
      if (ca) mw = 0;
      if ((n % 64) == 0) em = $urandom_range(0, 3) != 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
